// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Program counter and instruction-fetch front end for the control unit.
//   Executes PC commands (clear > load > increment > hold), fetches words
//   from a synchronous instruction memory (1-cycle read latency) and presents
//   a latched IR with a valid flag.
//
//   Build option: `define FETCH_REL_BRANCH_EN makes PC_LD a PC-relative branch
//   (PC <= PC + signed PC_TARGET). Without it, PC_LD loads PC_TARGET directly.
//
// Ports
//   Clock, Reset          clock; synchronous active-high reset
//   PC_CLR/PC_LD/PC_IC    PC commands; PC_CLR also aborts an in-flight fetch
//   PC_TARGET             load / branch operand
//   FETCH_REQ             pulse: fetch word at current PC
//   IM_RDATA              memory read data, valid the cycle after IM_EN
//   IM_EN, IM_ADDR        memory read strobe and address
//   IR, IR_VALID          fetched instruction and its valid flag
//   FETCH_BUSY            fetch in flight; new FETCH_REQ is ignored
//   FETCH_DROP            1-cycle pulse after an ignored FETCH_REQ
//   PC, PC_WRAP           program counter; sticky increment-wrap flag
module pc_fetch_unit #(
  parameter int ADDR_W   = 8,
  parameter int INSTR_W  = 16,
  parameter int RESET_PC = 0
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               PC_CLR,
  input  logic               PC_LD,
  input  logic               PC_IC,
  input  logic [ADDR_W-1:0]  PC_TARGET,
  input  logic               FETCH_REQ,
  input  logic [INSTR_W-1:0] IM_RDATA,
  output logic               IM_EN,
  output logic [ADDR_W-1:0]  IM_ADDR,
  output logic [INSTR_W-1:0] IR,
  output logic               IR_VALID,
  output logic               FETCH_BUSY,
  output logic               FETCH_DROP,
  output logic [ADDR_W-1:0]  PC,
  output logic               PC_WRAP
);

  localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);

  typedef enum logic [1:0] {F_IDLE, F_ISSUE, F_CAPTURE} fstate_t;

  fstate_t             state, state_nxt;
  logic [ADDR_W-1:0]   pc, pc_nxt;
  logic                pc_wrap, wrap_nxt;
  logic [ADDR_W-1:0]   fetch_addr;
  logic [INSTR_W-1:0]  ir;
  logic                ir_valid;
  logic                fetch_drop;
  logic                busy, accept, abort;

  assign busy   = (state != F_IDLE);
  // A request is only taken in idle; PC_CLR there does not block it.
  assign accept = !busy && FETCH_REQ;
  assign abort  = busy && PC_CLR;

  // Fetch FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      F_IDLE:    if (FETCH_REQ) state_nxt = F_ISSUE;
      F_ISSUE:   state_nxt = F_CAPTURE;
      F_CAPTURE: state_nxt = F_IDLE;
      default:   state_nxt = F_IDLE;
    endcase
    if (abort) state_nxt = F_IDLE;
  end

  // PC command decode: one action per cycle, clear > load > increment
  always_comb begin
    pc_nxt   = pc;
    wrap_nxt = pc_wrap;
    if (PC_CLR) begin
      pc_nxt   = RST_PC;
      wrap_nxt = 1'b0;
    end else if (PC_LD) begin
`ifdef FETCH_REL_BRANCH_EN
      // Two's-complement add of the same width is the signed offset mod 2^W.
      pc_nxt = pc + PC_TARGET;
`else
      pc_nxt = PC_TARGET;
`endif
    end else if (PC_IC) begin
      pc_nxt = pc + ADDR_W'(1);
      if (&pc) wrap_nxt = 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= F_IDLE;
      pc         <= RST_PC;
      pc_wrap    <= 1'b0;
      fetch_addr <= '0;
      ir         <= '0;
      ir_valid   <= 1'b0;
      fetch_drop <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      pc_wrap    <= wrap_nxt;
      fetch_drop <= FETCH_REQ && busy;
      if (accept) begin
        fetch_addr <= pc;              // pre-update PC
        ir_valid   <= 1'b0;
      end
      if (state == F_CAPTURE && !PC_CLR) begin
        ir       <= IM_RDATA;
        ir_valid <= 1'b1;
      end
      if (abort) ir_valid <= 1'b0;
    end
  end

  assign IM_EN      = (state == F_ISSUE);
  assign IM_ADDR    = fetch_addr;
  assign IR         = ir;
  assign IR_VALID   = ir_valid;
  assign FETCH_BUSY = busy;
  assign FETCH_DROP = fetch_drop;
  assign PC         = pc;
  assign PC_WRAP    = pc_wrap;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

`ifdef FETCH_REL_BRANCH_EN
  localparam bit REL = 1'b1;
`else
  localparam bit REL = 1'b0;
`endif

  logic        Clock = 1'b0;
  logic        Reset, PC_CLR, PC_LD, PC_IC, FETCH_REQ;
  logic [7:0]  PC_TARGET;
  logic [15:0] IM_RDATA;
  logic        IM_EN, IR_VALID, FETCH_BUSY, FETCH_DROP, PC_WRAP;
  logic [7:0]  IM_ADDR, PC;
  logic [15:0] IR;

  pc_fetch_unit #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(0)) dut (
    .Clock(Clock), .Reset(Reset), .PC_CLR(PC_CLR), .PC_LD(PC_LD), .PC_IC(PC_IC),
    .PC_TARGET(PC_TARGET), .FETCH_REQ(FETCH_REQ), .IM_RDATA(IM_RDATA),
    .IM_EN(IM_EN), .IM_ADDR(IM_ADDR), .IR(IR), .IR_VALID(IR_VALID),
    .FETCH_BUSY(FETCH_BUSY), .FETCH_DROP(FETCH_DROP), .PC(PC), .PC_WRAP(PC_WRAP)
  );

  always #5 Clock = ~Clock;

  // Synchronous instruction memory, 1-cycle read latency.
  logic [15:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'hA000 + 16'(i);
    mem[0] = 16'h1234;
  end
  always @(posedge Clock) if (IM_EN) IM_RDATA <= mem[IM_ADDR];

  typedef struct {
    logic clr, ld, ic; logic [7:0] tgt; logic req;
    logic [7:0] pc; logic wrap, irv; logic [15:0] ir;
    logic busy, imen; logic [7:0] imaddr; logic drop;
  } vec_t;

  vec_t vecs[$];
  int   applied = 0;
  int   errors  = 0;

  function automatic vec_t mk(logic clr, ld, ic, logic [7:0] tgt, logic req,
                              logic [7:0] pc, logic wrap, irv, logic [15:0] ir,
                              logic busy, imen, logic [7:0] imaddr, logic drop);
    vec_t v;
    v.clr = clr; v.ld = ld; v.ic = ic; v.tgt = tgt; v.req = req;
    v.pc = pc; v.wrap = wrap; v.irv = irv; v.ir = ir;
    v.busy = busy; v.imen = imen; v.imaddr = imaddr; v.drop = drop;
    return v;
  endfunction

  // Packed view: pc,wrap,irv,ir,busy,imen,imaddr,drop
  function automatic logic [36:0] pack_exp(vec_t v);
    return {v.pc, v.wrap, v.irv, v.ir, v.busy, v.imen, v.imaddr, v.drop};
  endfunction

  function automatic logic [36:0] pack_act();
    return {PC, PC_WRAP, IR_VALID, IR, FETCH_BUSY, IM_EN, IM_ADDR, FETCH_DROP};
  endfunction

  task automatic check(string name, logic [36:0] exp);
    logic [36:0] act;
    act = pack_act();
    applied++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got pc=%h wrap=%b irv=%b ir=%h busy=%b imen=%b imaddr=%h drop=%b, want pc=%h wrap=%b irv=%b ir=%h busy=%b imen=%b imaddr=%h drop=%b",
               name, act[36:29], act[28], act[27], act[26:11], act[10], act[9], act[8:1], act[0],
               exp[36:29], exp[28], exp[27], exp[26:11], exp[10], exp[9], exp[8:1], exp[0]);
    end
  endtask

  task automatic drive(logic clr, ld, ic, logic [7:0] tgt, logic req);
    PC_CLR = clr; PC_LD = ld; PC_IC = ic; PC_TARGET = tgt; FETCH_REQ = req;
  endtask

  initial begin
    logic [36:0] rexp;
    // Each row: inputs held for one cycle, outputs checked #1 after the edge.
    //             clr ld ic tgt   req | pc  wrap irv ir  busy imen addr drop
    vecs.push_back(mk(0,0,0,8'h00,1, 8'h00,0,0,16'h0000,1,1,8'h00,0)); // 0 issue
    vecs.push_back(mk(0,0,0,8'h00,0, 8'h00,0,0,16'h0000,1,0,8'h00,0)); // 1 capture
    vecs.push_back(mk(0,0,0,8'h00,0, 8'h00,0,1,16'h1234,0,0,8'h00,0)); // 2 IR valid
    vecs.push_back(mk(0,1,0,8'hFF,0, 8'hFF,0,1,16'h1234,0,0,8'h00,0)); // 3 load FF
    vecs.push_back(mk(0,0,1,8'h00,0, 8'h00,1,1,16'h1234,0,0,8'h00,0)); // 4 wrap
    vecs.push_back(mk(0,0,0,8'h00,0, 8'h00,1,1,16'h1234,0,0,8'h00,0)); // 5 sticky
    vecs.push_back(mk(1,0,0,8'h00,0, 8'h00,0,1,16'h1234,0,0,8'h00,0)); // 6 clr
    vecs.push_back(mk(0,1,0,8'h40,0, 8'h40,0,1,16'h1234,0,0,8'h00,0)); // 7 ld 40
    vecs.push_back(mk(1,1,1,8'h40,0, 8'h00,0,1,16'h1234,0,0,8'h00,0)); // 8 clr wins
    vecs.push_back(mk(0,1,1,8'h40,0, 8'h40,0,1,16'h1234,0,0,8'h00,0)); // 9 ld wins
    vecs.push_back(mk(1,0,0,8'h00,0, 8'h00,0,1,16'h1234,0,0,8'h00,0)); // 10
    vecs.push_back(mk(0,1,0,8'h20,0, 8'h20,0,1,16'h1234,0,0,8'h00,0)); // 11 pc=20
    vecs.push_back(mk(0,1,1,8'h40,0, REL ? 8'h60 : 8'h40,0,1,16'h1234,0,0,8'h00,0)); // 12
    vecs.push_back(mk(1,0,0,8'h00,0, 8'h00,0,1,16'h1234,0,0,8'h00,0)); // 13
    vecs.push_back(mk(0,1,0,8'h20,0, 8'h20,0,1,16'h1234,0,0,8'h00,0)); // 14
    vecs.push_back(mk(0,1,0,8'hF0,0, REL ? 8'h10 : 8'hF0,0,1,16'h1234,0,0,8'h00,0)); // 15 no wrap
    vecs.push_back(mk(1,0,0,8'h00,0, 8'h00,0,1,16'h1234,0,0,8'h00,0)); // 16
    vecs.push_back(mk(0,1,0,8'h05,0, 8'h05,0,1,16'h1234,0,0,8'h00,0)); // 17 pc=5
    vecs.push_back(mk(0,0,1,8'h00,1, 8'h06,0,0,16'h1234,1,1,8'h05,0)); // 18 req+ic
    vecs.push_back(mk(0,0,0,8'h00,1, 8'h06,0,0,16'h1234,1,0,8'h05,1)); // 19 dropped
    vecs.push_back(mk(0,0,0,8'h00,0, 8'h06,0,1,16'hA005,0,0,8'h05,0)); // 20 mem[5]
    vecs.push_back(mk(0,0,0,8'h00,1, 8'h06,0,0,16'hA005,1,1,8'h06,0)); // 21 issue
    vecs.push_back(mk(1,0,0,8'h00,0, 8'h00,0,0,16'hA005,0,0,8'h06,0)); // 22 abort
    vecs.push_back(mk(0,0,0,8'h00,0, 8'h00,0,0,16'hA005,0,0,8'h06,0)); // 23 IR held
    vecs.push_back(mk(0,0,0,8'h00,1, 8'h00,0,0,16'hA005,1,1,8'h00,0)); // 24
    vecs.push_back(mk(0,0,0,8'h00,0, 8'h00,0,0,16'hA005,1,0,8'h00,0)); // 25
    vecs.push_back(mk(0,0,0,8'h00,0, 8'h00,0,1,16'h1234,0,0,8'h00,0)); // 26 mem[0]
    vecs.push_back(mk(0,0,0,8'h00,1, 8'h00,0,0,16'h1234,1,1,8'h00,0)); // 27
    vecs.push_back(mk(1,0,0,8'h00,1, 8'h00,0,0,16'h1234,0,0,8'h00,1)); // 28 clr+req busy
    vecs.push_back(mk(0,0,0,8'h00,0, 8'h00,0,0,16'h1234,0,0,8'h00,0)); // 29
    vecs.push_back(mk(0,1,0,8'h07,0, 8'h07,0,0,16'h1234,0,0,8'h00,0)); // 30 pc=7
    vecs.push_back(mk(1,0,0,8'h00,1, 8'h00,0,0,16'h1234,1,1,8'h07,0)); // 31 clr+req idle
    vecs.push_back(mk(0,0,0,8'h00,0, 8'h00,0,0,16'h1234,1,0,8'h07,0)); // 32
    vecs.push_back(mk(0,0,0,8'h00,0, 8'h00,0,1,16'hA007,0,0,8'h07,0)); // 33 mem[7]
    vecs.push_back(mk(0,0,0,8'h00,1, 8'h00,0,0,16'hA007,1,1,8'h00,0)); // 34
    vecs.push_back(mk(0,0,0,8'h00,0, 8'h00,0,0,16'hA007,1,0,8'h00,0)); // 35
    vecs.push_back(mk(1,0,0,8'h00,0, 8'h00,0,0,16'hA007,0,0,8'h00,0)); // 36 abort in capture

    drive(0,0,0,8'h00,0);
    Reset = 1'b1;
    repeat (2) @(posedge Clock);
    #1;
    rexp = {8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0};
    check("reset", rexp);
    Reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].clr, vecs[i].ld, vecs[i].ic, vecs[i].tgt, vecs[i].req);
      @(posedge Clock); #1;
      check($sformatf("vec%0d", i), pack_exp(vecs[i]));
    end

    // FETCH_REQ held high: accepted every 3rd cycle, dropped in between.
    // PC=0 and IR=A007 on entry; the accepted fetches read mem[0].
    drive(0,0,0,8'h00,1);
    for (int k = 0; k < 6; k++) begin
      @(posedge Clock); #1;
      rexp = {8'h00, 1'b0, (k % 3 == 2), (k >= 2) ? 16'h1234 : 16'hA007,
              (k % 3 != 2), (k % 3 == 0), 8'h00, (k % 3 != 0)};
      check($sformatf("b2b%0d", k), rexp);
    end
    drive(0,0,0,8'h00,0);

    // Reset from a busy, wrapped state returns everything to reset values.
    drive(0,1,0,8'hFF,1);
    @(posedge Clock); #1;
    drive(0,0,1,8'h00,0);
    @(posedge Clock); #1;
    Reset = 1'b1;
    drive(0,0,0,8'h00,0);
    @(posedge Clock); #1;
    rexp = {8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0};
    check("reset2", rexp);
    Reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
    $finish;
  end

endmodule
